seq_scan_ctrl: RTL

//  Stream controller for serial pattern detection. Accepts DATA_W-bit words on a valid/ready

---
 rtl/seq_scan_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serializes words MSB-first, matches a sliding-window pattern, counts hits.
// Optional abort input is enabled by defining SEQ_SCAN_ABORT_EN.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W = 4,
  parameter int CNT_W = 16,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic              start,
`ifdef SEQ_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              det_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011);
  localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'((PAT_W < 4) ? PAT_W : 4);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [PAT_W-1:0]  pat_q;
  logic [PAT_W-1:0]  win_q;
  logic [PAT_W-1:0]  win_n;
  logic [PAT_W-1:0]  mask;
  logic [PAT_W:0]    win_sh;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_in;
  logic [LEN_W-1:0]  seen_q;
  logic [LEN_W-1:0]  seen_n;
  logic              ovl_q;
  logic [DATA_W-1:0] sh_q;
  logic [BC_W-1:0]   bcnt_q;
  logic              last_q;
  logic              hit;
  logic              take;
  logic              abort_now;

`ifdef SEQ_SCAN_ABORT_EN
  assign abort_now = abort && (state != IDLE);
`else
  assign abort_now = 1'b0;
`endif

  assign len_in    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign in_ready  = (state == LOAD) && !abort_now;
  assign take      = in_valid && in_ready;
  assign ser_valid = (state == SHIFT);
  assign ser_bit   = ser_valid && sh_q[DATA_W-1];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE) && !abort_now;

  // Window/match view including the bit currently on ser_bit
  always_comb begin
    win_sh = {win_q, ser_bit};
    win_n  = win_sh[PAT_W-1:0];
    seen_n = (seen_q == MAX_LEN) ? seen_q : seen_q + LEN_W'(1);
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len_q));
    end
    hit = ser_valid && !abort_now &&
          (len_q != '0) && (seen_n >= len_q) &&
          ((win_n & mask) == (pat_q & mask));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (take) state_n = SHIFT;
      SHIFT: begin
        if (bcnt_q == BC_W'(DATA_W - 1)) begin
          state_n = last_q ? DONE : LOAD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_now) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= DEF_PAT;
      len_q       <= DEF_LEN;
      ovl_q       <= 1'b1;
      win_q       <= '0;
      seen_q      <= '0;
      sh_q        <= '0;
      bcnt_q      <= '0;
      last_q      <= 1'b0;
      det_pulse   <= 1'b0;
      match_count <= '0;
    end else begin
      state     <= state_n;
      det_pulse <= hit;
      if (state == IDLE && cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= len_in;
        ovl_q <= cfg_overlap;
      end
      if (state == IDLE && start) begin
        win_q       <= '0;
        seen_q      <= '0;
        match_count <= '0;
      end
      if (take) begin
        sh_q   <= in_data;
        bcnt_q <= '0;
        last_q <= in_last;
      end
      if (ser_valid && !abort_now) begin
        sh_q   <= sh_q << 1;
        bcnt_q <= bcnt_q + BC_W'(1);
        if (hit && !ovl_q) begin
          win_q  <= '0;
          seen_q <= '0;
        end else begin
          win_q  <= win_n;
          seen_q <= seen_n;
        end
      end
      if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
